// File: rtl/fifo_word_serializer.sv
// Drains BITS-wide words from fifo_flops and emits them as BITS/OUT_BITS slices on a valid/ready stream.
// Optional macro SER_PARITY_EN adds out_par, the XOR-reduce of out_data.
module fifo_word_serializer #(
    parameter int BITS      = 16,
    parameter int OUT_BITS  = 4,
    parameter int MSB_FIRST = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BITS-1:0]     fifo_dout,
    input  logic                fifo_pndng,
    output logic                fifo_pop,
    output logic [OUT_BITS-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
`ifdef SER_PARITY_EN
    output logic                out_par,
`endif
    output logic                busy
);

    localparam int N  = BITS / OUT_BITS;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    generate
        if ((BITS % OUT_BITS) != 0 || BITS < OUT_BITS) begin : g_bad_width
            $error("fifo_word_serializer: BITS must be an integer multiple of OUT_BITS");
        end
    endgenerate

    typedef enum logic {EMPTY, SHIFT} state_t;

    state_t          state, state_n;
    logic [BITS-1:0] shreg, shreg_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            is_last;
    int              sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            shreg <= shreg_n;
            cnt   <= cnt_n;
        end
    end

    // Slice outputs are forced to zero outside SHIFT so reset clears them without waiting for an edge.
    always_comb begin
        is_last   = (cnt == LAST_CNT);
        sel       = (MSB_FIRST != 0) ? (N - 1 - int'(cnt)) : int'(cnt);
        out_valid = (state == SHIFT);
        busy      = (state == SHIFT);
        out_last  = (state == SHIFT) && is_last;
        out_data  = (state == SHIFT) ? OUT_BITS'(shreg >> (OUT_BITS * sel)) : '0;
    end

    always_comb begin
        state_n  = state;
        shreg_n  = shreg;
        cnt_n    = cnt;
        fifo_pop = 1'b0;
        case (state)
            EMPTY: begin
                if (fifo_pndng) begin
                    fifo_pop = 1'b1;
                    shreg_n  = fifo_dout;
                    cnt_n    = '0;
                    state_n  = SHIFT;
                end
            end
            SHIFT: begin
                if (out_ready) begin
                    if (!is_last) begin
                        cnt_n = cnt + 1'b1;
                    end else if (fifo_pndng) begin
                        // Reload on the last slice keeps the stream free of bubbles between words.
                        fifo_pop = 1'b1;
                        shreg_n  = fifo_dout;
                        cnt_n    = '0;
                    end else begin
                        cnt_n   = '0;
                        state_n = EMPTY;
                    end
                end
            end
            default: state_n = EMPTY;
        endcase
        if (rst) begin
            fifo_pop = 1'b0;
        end
    end

`ifdef SER_PARITY_EN
    assign out_par = ^out_data;
`endif

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Table-driven bench for fifo_word_serializer: a queue models fifo_flops, with LSB-first and MSB-first instances.
module tb_fifo_word_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] fifo_dout;
    logic        fifo_pndng;
    logic        fifo_pop;
    logic        out_ready;
    logic [3:0]  out_data;
    logic        out_valid;
    logic        out_last;
    logic        busy;
    logic        m_pop;
    logic [3:0]  m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_busy;
`ifdef SER_PARITY_EN
    logic        out_par;
    logic        m_par;
`endif

    always #5 clk = ~clk;

    fifo_word_serializer #(.BITS(16), .OUT_BITS(4), .MSB_FIRST(0)) dut (
        .clk(clk), .rst(rst), .fifo_dout(fifo_dout), .fifo_pndng(fifo_pndng),
        .fifo_pop(fifo_pop), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last),
`ifdef SER_PARITY_EN
        .out_par(out_par),
`endif
        .busy(busy)
    );

    fifo_word_serializer #(.BITS(16), .OUT_BITS(4), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .rst(rst), .fifo_dout(fifo_dout), .fifo_pndng(fifo_pndng),
        .fifo_pop(m_pop), .out_data(m_data), .out_valid(m_valid),
        .out_ready(out_ready), .out_last(m_last),
`ifdef SER_PARITY_EN
        .out_par(m_par),
`endif
        .busy(m_busy)
    );

    typedef struct {
        logic        push;
        logic [15:0] word;
        logic        ready;
        logic        pop;
        logic        valid;
        logic [3:0]  data;
        logic [3:0]  mdata;
        logic        last;
        logic        busy;
        logic        par;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] q[$];
    logic        popPending;
    int          popCount;
    int          applied;
    int          miscompares;
    int          popBase;

    function automatic void addVec(input logic push, input logic [15:0] word, input logic ready,
                                   input logic pop, input logic valid, input logic [3:0] data,
                                   input logic [3:0] mdata, input logic last, input logic bsy,
                                   input logic par);
        vec_t v;
        v.push = push; v.word = word; v.ready = ready; v.pop = pop; v.valid = valid;
        v.data = data; v.mdata = mdata; v.last = last; v.busy = bsy; v.par = par;
        vecs.push_back(v);
    endfunction

    // One cycle: retire the previous pop from the model FIFO, drive inputs at negedge, then sample.
    task automatic applyStimulus(input logic push, input logic [15:0] word, input logic ready,
                                 input logic rstv);
        @(negedge clk);
        if (popPending && q.size() > 0) begin
            q.delete(0);
        end
        popPending = 1'b0;
        if (push) begin
            q.push_back(word);
        end
        fifo_pndng = (q.size() != 0);
        fifo_dout  = fifo_pndng ? q[0] : 16'h0000;
        out_ready  = ready;
        rst        = rstv;
        #1;
        popPending = fifo_pop;
        if (fifo_pop) begin
            popCount++;
        end
        applied++;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkCore(input string tag, input logic pop, input logic valid,
                             input logic [3:0] data, input logic last, input logic bsy);
        checkOutput({tag, " fifo_pop"},  4'(fifo_pop),  4'(pop));
        checkOutput({tag, " out_valid"}, 4'(out_valid), 4'(valid));
        checkOutput({tag, " out_data"},  out_data,      data);
        checkOutput({tag, " out_last"},  4'(out_last),  4'(last));
        checkOutput({tag, " busy"},      4'(busy),      4'(bsy));
    endtask

    initial begin
        rst         = 1'b0;
        out_ready   = 1'b0;
        fifo_pndng  = 1'b0;
        fifo_dout   = 16'h0000;
        popPending  = 1'b0;
        popCount    = 0;
        applied     = 0;
        miscompares = 0;

        // Single word 0xA5C3, free-running sink.
        addVec(1, 16'hA5C3, 1, 1, 0, 4'h0, 4'h0, 0, 0, 0);
        addVec(0, 16'h0000, 1, 0, 1, 4'h3, 4'hA, 0, 1, 0);
        addVec(0, 16'h0000, 1, 0, 1, 4'hC, 4'h5, 0, 1, 0);
        addVec(0, 16'h0000, 1, 0, 1, 4'h5, 4'hC, 0, 1, 0);
        addVec(0, 16'h0000, 1, 0, 1, 4'hA, 4'h3, 1, 1, 0);
        addVec(0, 16'h0000, 1, 0, 0, 4'h0, 4'h0, 0, 0, 0);
        // Same word with three cycles of backpressure on the first slice.
        addVec(1, 16'hA5C3, 0, 1, 0, 4'h0, 4'h0, 0, 0, 0);
        addVec(0, 16'h0000, 0, 0, 1, 4'h3, 4'hA, 0, 1, 0);
        addVec(0, 16'h0000, 0, 0, 1, 4'h3, 4'hA, 0, 1, 0);
        addVec(0, 16'h0000, 0, 0, 1, 4'h3, 4'hA, 0, 1, 0);
        addVec(0, 16'h0000, 1, 0, 1, 4'h3, 4'hA, 0, 1, 0);
        addVec(0, 16'h0000, 1, 0, 1, 4'hC, 4'h5, 0, 1, 0);
        addVec(0, 16'h0000, 1, 0, 1, 4'h5, 4'hC, 0, 1, 0);
        addVec(0, 16'h0000, 1, 0, 1, 4'hA, 4'h3, 1, 1, 0);
        addVec(0, 16'h0000, 1, 0, 0, 4'h0, 4'h0, 0, 0, 0);
        // Back-to-back 0x0001, 0x0002: second pop lands on the first word's last slice.
        addVec(1, 16'h0001, 1, 1, 0, 4'h0, 4'h0, 0, 0, 0);
        addVec(1, 16'h0002, 1, 0, 1, 4'h1, 4'h0, 0, 1, 1);
        addVec(0, 16'h0000, 1, 0, 1, 4'h0, 4'h0, 0, 1, 0);
        addVec(0, 16'h0000, 1, 0, 1, 4'h0, 4'h0, 0, 1, 0);
        addVec(0, 16'h0000, 1, 1, 1, 4'h0, 4'h1, 1, 1, 0);
        addVec(0, 16'h0000, 1, 0, 1, 4'h2, 4'h0, 0, 1, 1);
        addVec(0, 16'h0000, 1, 0, 1, 4'h0, 4'h0, 0, 1, 0);
        addVec(0, 16'h0000, 1, 0, 1, 4'h0, 4'h0, 0, 1, 0);
        addVec(0, 16'h0000, 1, 0, 1, 4'h0, 4'h2, 1, 1, 0);
        addVec(0, 16'h0000, 1, 0, 0, 4'h0, 4'h0, 0, 0, 0);
        // Word 0x0007: odd parity on the first slice.
        addVec(1, 16'h0007, 1, 1, 0, 4'h0, 4'h0, 0, 0, 0);
        addVec(0, 16'h0000, 1, 0, 1, 4'h7, 4'h0, 0, 1, 1);
        addVec(0, 16'h0000, 1, 0, 1, 4'h0, 4'h0, 0, 1, 0);
        addVec(0, 16'h0000, 1, 0, 1, 4'h0, 4'h0, 0, 1, 0);
        addVec(0, 16'h0000, 1, 0, 1, 4'h0, 4'h7, 1, 1, 0);
        addVec(0, 16'h0000, 1, 0, 0, 4'h0, 4'h0, 0, 0, 0);

        #1 rst = 1'b1;
        applyStimulus(1, 16'hBEEF, 1, 1);
        checkCore("reset0", 0, 0, 4'h0, 0, 0);
        for (int i = 1; i < 5; i++) begin
            applyStimulus(0, 16'h0000, 1, 1);
            checkCore($sformatf("reset%0d", i), 0, 0, 4'h0, 0, 0);
        end
        @(negedge clk);
        q.delete();
        fifo_pndng = 1'b0;
        fifo_dout  = 16'h0000;
        rst        = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].push, vecs[i].word, vecs[i].ready, 1'b0);
            checkCore($sformatf("vec%0d", i), vecs[i].pop, vecs[i].valid, vecs[i].data,
                      vecs[i].last, vecs[i].busy);
            checkOutput($sformatf("vec%0d msb out_data", i), m_data, vecs[i].mdata);
`ifdef SER_PARITY_EN
            checkOutput($sformatf("vec%0d out_par", i), 4'(out_par), 4'(vecs[i].par));
`endif
        end

        // Reset after two slices of 0x1234 while 0x5678 waits in the FIFO.
        popBase = popCount;
        applyStimulus(1, 16'h1234, 1, 0);
        checkCore("midrst pop", 1, 0, 4'h0, 0, 0);
        applyStimulus(1, 16'h5678, 1, 0);
        checkCore("midrst s0", 0, 1, 4'h4, 0, 1);
        applyStimulus(0, 16'h0000, 1, 0);
        checkCore("midrst s1", 0, 1, 4'h3, 0, 1);
        #2 rst = 1'b1;
        #1;
        applied++;
        checkCore("midrst async", 0, 0, 4'h0, 0, 0);
        applyStimulus(0, 16'h0000, 1, 1);
        checkCore("midrst hold0", 0, 0, 4'h0, 0, 0);
        applyStimulus(0, 16'h0000, 1, 1);
        checkCore("midrst hold1", 0, 0, 4'h0, 0, 0);
        applyStimulus(0, 16'h0000, 1, 0);
        checkCore("midrst repop", 1, 0, 4'h0, 0, 0);
        applyStimulus(0, 16'h0000, 1, 0);
        checkCore("midrst n0", 0, 1, 4'h8, 0, 1);
        applyStimulus(0, 16'h0000, 1, 0);
        checkCore("midrst n1", 0, 1, 4'h7, 0, 1);
        applyStimulus(0, 16'h0000, 1, 0);
        checkCore("midrst n2", 0, 1, 4'h6, 0, 1);
        applyStimulus(0, 16'h0000, 1, 0);
        checkCore("midrst n3", 0, 1, 4'h5, 1, 1);
        applyStimulus(0, 16'h0000, 1, 0);
        checkCore("midrst idle", 0, 0, 4'h0, 0, 0);
        checkOutput("midrst pop count", 4'(popCount - popBase), 4'd2);
        checkOutput("midrst fifo left", 4'(q.size()), 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
